// File: rtl/freq_meter_pkg.sv
// Shared types and default sizing for the gated frequency meter.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2
    } state_e;

    localparam int GATE_CYCLES_DEFAULT = 50_000_000;
    localparam int CNT_W_DEFAULT       = 26;

endpackage

// File: rtl/freq_meter_sig_sync_edge.sv
// Conditions the measured signal and emits a one-cycle pulse on each rising edge.
// FREQ_METER_SYNC_EN adds a 2-flop synchronizer in front of the history flop.
module freq_meter_sig_sync_edge (
    input  logic clk,
    input  logic srst,
    input  logic sig_in,
    output logic edge_out
);
    logic sig_s;
    logic prev_q, prev_d;

`ifdef FREQ_METER_SYNC_EN
    logic [1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[0], sig_in};
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sig_s = sync_q[1];
`else
    assign sig_s = sig_in;
`endif

    // History runs in every FSM state so a level held across gate entry is not an edge.
    always_comb begin
        prev_d = sig_s;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign edge_out = sig_s & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts rising edges of iSig over GATE_CYCLES clocks and strobes the result.
// Define FREQ_METER_SYNC_EN to synchronize an asynchronous iSig before edge detection.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iEn,
    input  logic             iSig,
    output logic [CNT_W-1:0] oFreq,
    output logic             oValid,
    output logic             oOvf,
    output logic             oBusy
);
    localparam int                GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  freq_q, freq_d;
    logic              sat_q, sat_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, valid_d;
    logic              edge_pulse;
    logic              gating;

    freq_meter_sig_sync_edge u_edge (
        .clk     (iClk),
        .srst    (iRst),
        .sig_in  (iSig),
        .edge_out(edge_pulse)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Dropping iEn wins over reaching the last gate cycle: an aborted window never reports.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (iEn) state_d = GATE;
            GATE: begin
                if (!iEn) begin
                    state_d = IDLE;
                end else if (gate_cnt_q == GATE_LAST) begin
                    state_d = LATCH;
                end
            end
            LATCH:   state_d = iEn ? GATE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign gating = (state_q == GATE) && iEn;

    always_comb begin
        gate_cnt_d = '0;
        cnt_d      = '0;
        sat_d      = 1'b0;
        freq_d     = freq_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;
        if (gating) begin
            gate_cnt_d = gate_cnt_q + GATE_W'(1);
            cnt_d      = cnt_q;
            sat_d      = sat_q;
            if (edge_pulse) begin
                if (cnt_q == CNT_MAX) begin
                    sat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
        if (state_q == LATCH) begin
            freq_d  = cnt_q;
            ovf_d   = sat_q;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            gate_cnt_q <= '0;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
            freq_q     <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            gate_cnt_q <= gate_cnt_d;
            cnt_q      <= cnt_d;
            sat_q      <= sat_d;
            freq_q     <= freq_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    assign oFreq  = freq_q;
    assign oOvf   = ovf_q;
    assign oValid = valid_q;
    assign oBusy  = (state_q == GATE);

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: a window-level reference model predicts every strobe,
// a monitor compares DUT outputs against it every cycle.
`timescale 1ns/1ps
module tb_freq_meter;
    localparam int GATE = 100;
    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;
`ifdef FREQ_METER_SYNC_EN
    localparam int LAG = 2;
`else
    localparam int LAG = 0;
`endif
    localparam int MAXC = 20000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic         sig = 1'b0;
    logic [W-1:0] freq;
    logic         valid;
    logic         ovf;
    logic         busy;

    freq_meter #(.GATE_CYCLES(GATE), .CNT_W(W)) dut (
        .iClk  (clk),
        .iRst  (rst),
        .iEn   (en),
        .iSig  (sig),
        .oFreq (freq),
        .oValid(valid),
        .oOvf  (ovf),
        .oBusy (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = -1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (window arithmetic over sampled history) ----------------
    typedef struct {
        int cyc;
        int freq;
        int ovf;
    } exp_t;

    exp_t sb_q[$];
    bit   s_hist[MAXC];
    int   mask      = -1;
    bit   win_open  = 1'b0;
    int   win_a     = 0;
    int   hold_freq = 0;
    int   hold_ovf  = 0;
    bit   exp_busy  = 1'b0;

    // Conditioned signal seen by the edge detector at clock edge k; history before the
    // most recent reset reads as 0 because reset clears the synchronizer and history.
    function automatic bit cond_sig(input int k);
        int j;
        j = k - LAG;
        if (j < 0 || j <= mask) return 1'b0;
        return s_hist[j];
    endfunction

    always @(posedge clk) begin
        int   total;
        exp_t e;
        cyc++;
        if (cyc < MAXC) s_hist[cyc] = sig;
        if (rst) begin
            mask      = cyc;
            win_open  = 1'b0;
            hold_freq = 0;
            hold_ovf  = 0;
        end else if (win_open && cyc <= win_a + GATE) begin
            if (!en) win_open = 1'b0;
        end else if (win_open) begin
            total = 0;
            for (int k = win_a + 1; k <= win_a + GATE; k++) begin
                if (cond_sig(k) && !cond_sig(k - 1)) total++;
            end
            e.cyc     = cyc;
            e.freq    = (total > MAXV) ? MAXV : total;
            e.ovf     = (total > MAXV) ? 1 : 0;
            hold_freq = e.freq;
            hold_ovf  = e.ovf;
            sb_q.push_back(e);
            if (en) win_a = cyc;
            else    win_open = 1'b0;
        end else if (en) begin
            win_open = 1'b1;
            win_a    = cyc;
        end
        exp_busy = win_open && (cyc < win_a + GATE);
    end

    // ---------------- monitor ----------------
    int   strobe_cnt  = 0;
    int   last_freq   = 0;
    int   last_ovf    = 0;
    int   last_strobe = 0;
    exp_t mon_e;

    always @(posedge clk) begin
        bit exp_v;
        #1;
        if (cyc >= 0) begin
            check("busy", busy, exp_busy);
            check("freq_reg", freq, hold_freq);
            check("ovf_reg", ovf, hold_ovf);
            exp_v = (sb_q.size() > 0) && (sb_q[0].cyc == cyc);
            check("valid", valid, exp_v);
            if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                mon_e = sb_q.pop_front();
                if (valid) begin
                    check("strobe_freq", freq, mon_e.freq);
                    check("strobe_ovf", ovf, mon_e.ovf);
                end
            end
            if (valid) begin
                strobe_cnt++;
                last_freq   = freq;
                last_ovf    = ovf;
                last_strobe = cyc;
                $display("strobe cycle=%0d freq=%0d ovf=%0d", cyc, freq, ovf);
            end
        end
    end

    // ---------------- stimulus ----------------
    int sig_period = 0;
    int sig_hi     = 0;
    bit sig_level  = 1'b0;
    bit sig_rand   = 1'b0;
    int phase      = 0;

    task automatic tick();
        @(negedge clk);
        phase++;
        if (sig_rand)            sig = 1'($urandom_range(0, 1));
        else if (sig_period > 0) sig = ((phase % sig_period) < sig_hi);
        else                     sig = sig_level;
    endtask

    task automatic run(input int k);
        repeat (k) tick();
    endtask

    task automatic set_period(input int p, input int h);
        sig_rand   = 1'b0;
        sig_period = p;
        sig_hi     = h;
        phase      = 0;
    endtask

    task automatic set_level(input bit l);
        sig_rand   = 1'b0;
        sig_period = 0;
        sig_level  = l;
        sig        = l;
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int b;
        b = 0;
        while (strobe_cnt < target && b < budget) begin
            tick();
            b++;
        end
        if (strobe_cnt < target) check("strobe_wait", strobe_cnt, target);
    endtask

    initial begin
        int a;
        int s1;
        int n0;

        rst = 1'b1;
        run(3);
        check("rst_freq", freq, 0);
        check("rst_valid", valid, 0);
        check("rst_ovf", ovf, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        // Period-10 square wave, back-to-back windows
        set_period(10, 5);
        run(30);
        en = 1'b1;
        a  = cyc + 1;
        wait_strobes(strobe_cnt + 1, GATE + 20);
        check("t1_latency", last_strobe - a, GATE + 1);
        check("t1_freq", last_freq, 10);
        check("t1_ovf", last_ovf, 0);
        s1 = last_strobe;
        wait_strobes(strobe_cnt + 1, GATE + 20);
        check("t1_spacing", last_strobe - s1, GATE + 1);
        check("t1_freq2", last_freq, 10);

        // Abort at gate cycle 50 of the following window
        a = last_strobe;
        run(a + 50 - cyc);
        check("t4_busy_before", busy, 1);
        en = 1'b0;
        n0 = strobe_cnt;
        tick();
        check("t4_busy_after", busy, 0);
        run(GATE + 20);
        check("t4_no_valid", strobe_cnt, n0);
        check("t4_freq_held", freq, 10);

        // Level held high through a window
        set_level(1'b1);
        run(10);
        n0 = strobe_cnt;
        en = 1'b1;
        wait_strobes(n0 + 1, GATE + 20);
        en = 1'b0;
        check("t2_freq", last_freq, 0);
        run(GATE + 20);
        check("t2_once", strobe_cnt, n0 + 1);

        // Saturation, then recovery
        set_period(2, 1);
        run(10);
        en = 1'b1;
        wait_strobes(strobe_cnt + 1, GATE + 20);
        en = 1'b0;
        check("t3_sat_freq", last_freq, MAXV);
        check("t3_sat_ovf", last_ovf, 1);
        set_period(20, 10);
        run(30);
        en = 1'b1;
        wait_strobes(strobe_cnt + 1, GATE + 20);
        en = 1'b0;
        check("t3_freq", last_freq, 5);
        check("t3_ovf", last_ovf, 0);
        run(5);

        // Reset in gate cycle 40, then a fresh window
        set_period(10, 5);
        run(20);
        en = 1'b1;
        a  = cyc + 1;
        run(41);
        rst = 1'b1;
        tick();
        check("t5_freq", freq, 0);
        check("t5_valid", valid, 0);
        check("t5_ovf", ovf, 0);
        check("t5_busy", busy, 0);
        rst = 1'b0;
        a   = cyc + 1;
        wait_strobes(strobe_cnt + 1, GATE + 20);
        check("t5_latency", last_strobe - a, GATE + 1);
        check("t5_freq_new", last_freq, 10);
        en = 1'b0;
        run(5);

        // Edge on the final gate cycle counts; edge in the LATCH cycle does not
        set_level(1'b0);
        run(10);
        en = 1'b1;
        a  = cyc + 1;
        run(a + GATE - LAG - 1 - cyc);
        set_level(1'b1);
        wait_strobes(strobe_cnt + 1, GATE + 20);
        check("t6_final_edge", last_freq, 1);
        a = last_strobe;
        run(20);
        set_level(1'b0);
        run(a + GATE - LAG - cyc);
        set_level(1'b1);
        wait_strobes(strobe_cnt + 1, GATE + 20);
        check("t6_latch_edge", last_freq, 0);
        wait_strobes(strobe_cnt + 1, GATE + 20);
        check("t6_latch_edge_next", last_freq, 0);
        en = 1'b0;
        run(5);

        // Randomized traffic: patterns, aborts, resets
        for (int r = 0; r < 14; r++) begin
            int p;
            if ($urandom_range(0, 3) == 0) begin
                sig_rand = 1'b1;
            end else begin
                p = int'($urandom_range(2, 30));
                set_period(p, int'($urandom_range(1, p - 1)));
            end
            en = 1'b1;
            run(int'($urandom_range(50, 350)));
            case ($urandom_range(0, 5))
                0: begin
                    rst = 1'b1;
                    run(int'($urandom_range(1, 2)));
                    rst = 1'b0;
                end
                1, 2: begin
                    en = 1'b0;
                    run(int'($urandom_range(1, 20)));
                end
                default: ;
            endcase
        end

        en = 1'b0;
        run(2 * GATE + 10);
        check("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
